mc_control: RTL

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mc_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch/decode/execute
// for R-type, lw, sw, beq, j and addi; pc_en is the only combinational output.
module mc_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       pc_en,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_t;

    state_t cur, nxt;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (rst) cur <= FETCH;
        else     cur <= nxt;
    end

    // Next state and Moore outputs; unused encodings fall to FETCH with all outputs low.
    always_comb begin
        nxt  = FETCH;
        ctrl = '0;
        case (cur)
            FETCH: begin
                nxt            = DECODE;
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.pc_write  = 1'b1;
            end
            DECODE: begin
                ctrl.alu_src_b = 2'b11;
                case (op)
                    OP_RTYPE:     nxt = EXEC;
                    OP_LW, OP_SW: nxt = MEMADR;
                    OP_BEQ:       nxt = BRANCH;
                    OP_J:         nxt = JUMP;
                    OP_ADDI:      nxt = ADDIEX;
                    default:      nxt = FETCH;
                endcase
            end
            MEMADR: begin
                nxt            = (op == OP_LW) ? MEMRD : MEMWR;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
            end
            MEMRD: begin
                nxt           = MEMWB;
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            EXEC: begin
                nxt            = ALUWB;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = 2'b10;
            end
            ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = 2'b01;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = 2'b10;
            end
            ADDIEX: begin
                nxt            = ADDIWB;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
            end
            ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            default: begin
                nxt = FETCH;
            end
        endcase
    end

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign IRWrite     = ctrl.ir_write;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    // Branch resolves in the same cycle the ALU compares; zero only matters when PCWriteCond is high.
    assign pc_en       = ctrl.pc_write | (ctrl.pc_write_cond & zero);
    assign state       = cur;

endmodule
